// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   ALU_W        : ALU data width
//   ALU_ADD..OR  : 3-bit ALU command encodings
//   ST_*         : sequencer FSM state encoding
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between a controller and the sequencer.
//   req_valid/req_ready  : request handshake, carries req_a, req_b, req_cmd
//   resp_valid/resp_ready: response handshake, carries result, flags, cmd
// master = requesting controller, slave = alu_sequencer.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [ALU_W-1:0] req_a;
    logic [ALU_W-1:0] req_b;
    logic [2:0]       req_cmd;

    logic             resp_valid;
    logic             resp_ready;
    logic [ALU_W-1:0] resp_result;
    logic             resp_carryout;
    logic             resp_zero;
    logic             resp_overflow;
    logic [2:0]       resp_cmd;

    modport master (
        output req_valid, req_a, req_b, req_cmd, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_carryout,
               resp_zero, resp_overflow, resp_cmd
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cmd, resp_ready,
        output req_ready, resp_valid, resp_result, resp_carryout,
               resp_zero, resp_overflow, resp_cmd
    );

endinterface

// File: rtl/alu_sequencer_settle_timer.sv
// settle_timer: loadable down-counter that marks the end of the ALU settle
// interval.
//   clk, rst_n : clock, async active-low reset
//   load       : reload with SETTLE_CYCLES-1
//   en         : decrement while nonzero
//   zero       : counter has reached 0
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    // SETTLE_CYCLES-1 always fits in clog2(SETTLE_CYCLES) bits; keep at
    // least one bit so SETTLE_CYCLES=1 still elaborates.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (en && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: registers a request into stable ALU operands, waits
// SETTLE_CYCLES edges for the combinational ALU to settle, captures the
// result and flags, and returns them over a response handshake.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : request/response handshakes
//   alu_operandA/B, alu_command : registered drive into the ALU
//   alu_result, alu_carryout/zero/overflow : ALU outputs
//   txn_count           : completed response handshakes, wrapping
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_sequencer_if.slave   bus,
    output logic [ALU_W-1:0] alu_operandA,
    output logic [ALU_W-1:0] alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic [CNT_W-1:0] txn_count
);

    logic [1:0]       state;
    logic             accept;
    logic             resp_done;
    logic             timer_zero;
    logic [ALU_W-1:0] res_q;
    logic             co_q, zf_q, ov_q;
    logic [2:0]       cmd_q;

    // Ready/valid derive purely from state, so they can never both be high.
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign accept         = bus.req_valid && bus.req_ready;
    assign resp_done      = bus.resp_valid && bus.resp_ready;

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (state == ST_SETTLE),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            alu_operandA <= '0;
            alu_operandB <= '0;
            alu_command  <= ALU_ADD;
            res_q        <= '0;
            co_q         <= 1'b0;
            zf_q         <= 1'b0;
            ov_q         <= 1'b0;
            cmd_q        <= ALU_ADD;
            txn_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // ALU inputs only move here, keeping them glitch-free
                    // for the whole settle interval.
                    if (accept) begin
                        alu_operandA <= bus.req_a;
                        alu_operandB <= bus.req_b;
                        alu_command  <= bus.req_cmd;
                        state        <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        res_q <= alu_result;
                        co_q  <= alu_carryout;
                        zf_q  <= alu_zero;
                        ov_q  <= alu_overflow;
                        cmd_q <= alu_command;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_done) begin
                        txn_count <= txn_count + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.resp_result   = res_q;
    assign bus.resp_carryout = co_q;
    assign bus.resp_zero     = zf_q;
    assign bus.resp_overflow = ov_q;
    assign bus.resp_cmd      = cmd_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: SETTLE_CYCLES=4, CNT_W=16.  u1: SETTLE_CYCLES=1, CNT_W=4 (short wrap).
    alu_sequencer_if bi0 ();
    alu_sequencer_if bi1 ();

    logic [31:0] opa0, opb0, res0, opa1, opb1, res1;
    logic [2:0]  cmd0, cmd1;
    logic        co0, z0, ov0, co1, z1, ov1;
    logic [15:0] txn0;
    logic [3:0]  txn1;

    alu_sequencer #(.SETTLE_CYCLES(4), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bi0),
        .alu_operandA(opa0), .alu_operandB(opb0), .alu_command(cmd0),
        .alu_result(res0), .alu_carryout(co0), .alu_zero(z0),
        .alu_overflow(ov0), .txn_count(txn0)
    );

    alu_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bi1),
        .alu_operandA(opa1), .alu_operandB(opb1), .alu_command(cmd1),
        .alu_result(res1), .alu_carryout(co1), .alu_zero(z1),
        .alu_overflow(ov1), .txn_count(txn1)
    );

    // Behavioural stand-in for the combinational ALU: {carry, overflow, result}
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic co, ov;
        s = '0; r = '0; co = 1'b0; ov = 1'b0;
        case (c)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_AND:  r = a & b;
            ALU_NAND: r = ~(a & b);
            ALU_NOR:  r = ~(a | b);
            default:  r = a | b;
        endcase
        return {co, ov, r};
    endfunction

    always_comb begin
        {co0, ov0, res0} = alu_f(opa0, opb0, cmd0);
        z0 = (res0 == 32'd0);
        {co1, ov1, res1} = alu_f(opa1, opb1, cmd1);
        z1 = (res1 == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request on u0 and return after the accept edge.
    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        int n;
        bi0.req_a = a; bi0.req_b = b; bi0.req_cmd = c; bi0.req_valid = 1'b1;
        n = 0;
        while (!bi0.req_ready && n < 50) begin step(); n++; end
        chk("req_ready_before_send", {63'd0, bi0.req_ready}, 64'd1);
        step();
        bi0.req_valid = 1'b0;
    endtask

    // Count edges after the accept edge until resp_valid is seen.
    task automatic wait_resp0(output int n);
        n = 0;
        while (!bi0.resp_valid && n < 50) begin step(); n++; end
    endtask

    task automatic finish0();
        bi0.resp_ready = 1'b1;
        step();
        bi0.resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        bi0.req_valid = 0; bi0.req_a = 0; bi0.req_b = 0; bi0.req_cmd = 0; bi0.resp_ready = 0;
        bi1.req_valid = 0; bi1.req_a = 0; bi1.req_b = 0; bi1.req_cmd = 0; bi1.resp_ready = 0;

        // Reset values
        #12;
        chk("rst_req_ready",  {63'd0, bi0.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, bi0.resp_valid}, 64'd0);
        chk("rst_opA",        {32'd0, opa0}, 64'd0);
        chk("rst_opB",        {32'd0, opb0}, 64'd0);
        chk("rst_cmd",        {61'd0, cmd0}, 64'd0);
        chk("rst_result",     {32'd0, bi0.resp_result}, 64'd0);
        chk("rst_resp_cmd",   {61'd0, bi0.resp_cmd}, 64'd0);
        chk("rst_flags",      {61'd0, bi0.resp_carryout, bi0.resp_zero, bi0.resp_overflow}, 64'd0);
        chk("rst_txn",        {48'd0, txn0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD 5+7: resp_valid first seen after the E+4 edge
        send0(32'd5, 32'd7, ALU_ADD);
        wait_resp0(n);
        chk("add_latency", 64'(n), 64'd4);
        chk("add_result",  {32'd0, bi0.resp_result}, 64'd12);
        chk("add_flags",   {61'd0, bi0.resp_carryout, bi0.resp_zero, bi0.resp_overflow}, 64'd0);
        chk("add_cmd",     {61'd0, bi0.resp_cmd}, 64'd0);
        chk("add_no_ready_in_resp", {63'd0, bi0.req_ready}, 64'd0);
        finish0();
        chk("add_valid_drop", {63'd0, bi0.resp_valid}, 64'd0);
        chk("add_ready_back", {63'd0, bi0.req_ready}, 64'd1);
        chk("add_result_held", {32'd0, bi0.resp_result}, 64'd12);
        chk("add_txn", {48'd0, txn0}, 64'd1);

        // SUB overflow: 0x80000000 - 1
        send0(32'h8000_0000, 32'd1, ALU_SUB);
        wait_resp0(n);
        chk("sub_ovf_result", {32'd0, bi0.resp_result}, 64'h7FFF_FFFF);
        chk("sub_ovf_flag",   {63'd0, bi0.resp_overflow}, 64'd1);
        chk("sub_ovf_cmd",    {61'd0, bi0.resp_cmd}, 64'd1);
        finish0();

        // SUB 9-9 -> zero
        send0(32'd9, 32'd9, ALU_SUB);
        wait_resp0(n);
        chk("sub_zero_result", {32'd0, bi0.resp_result}, 64'd0);
        chk("sub_zero_flag",   {63'd0, bi0.resp_zero}, 64'd1);
        finish0();

        // SLT -1 < 1, then swapped
        send0(32'hFFFF_FFFF, 32'd1, ALU_SLT);
        wait_resp0(n);
        chk("slt_result", {32'd0, bi0.resp_result}, 64'd1);
        finish0();
        send0(32'd1, 32'hFFFF_FFFF, ALU_SLT);
        wait_resp0(n);
        chk("slt_swap_result", {32'd0, bi0.resp_result}, 64'd0);
        finish0();

        // NAND
        send0(32'hFFFF_0000, 32'hFF00_FF00, ALU_NAND);
        wait_resp0(n);
        chk("nand_result", {32'd0, bi0.resp_result}, 64'h00FF_FFFF);
        chk("nand_cmd",    {61'd0, bi0.resp_cmd}, 64'd5);
        finish0();

        // Requests during SETTLE/RESP are ignored; RESP holds while resp_ready low
        send0(32'h1234_5678, 32'hFFFF_0000, ALU_XOR);
        bi0.req_a = 32'hDEAD_BEEF; bi0.req_b = 32'd3; bi0.req_cmd = ALU_OR; bi0.req_valid = 1'b1;
        step();
        chk("settle_opA_hold", {32'd0, opa0}, 64'h1234_5678);
        chk("settle_no_ready", {63'd0, bi0.req_ready}, 64'd0);
        bi0.req_valid = 1'b0;
        wait_resp0(n);
        for (int i = 0; i < 10; i++) begin
            bi0.req_valid = i[0];
            step();
            chk("hold_result", {32'd0, bi0.resp_result}, 64'hEDCB_5678);
            chk("hold_valid",  {62'd0, bi0.resp_valid, bi0.req_ready}, 64'd2);
        end
        bi0.req_valid = 1'b0;
        chk("hold_opA", {32'd0, opa0}, 64'h1234_5678);
        chk("hold_cmd", {61'd0, bi0.resp_cmd}, 64'd2);
        finish0();
        chk("hold_txn", {48'd0, txn0}, 64'd7);

        // Reset mid-SETTLE: immediate reset values, no response afterwards
        send0(32'd1, 32'd1, ALU_ADD);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready",  {63'd0, bi0.req_ready}, 64'd1);
        chk("mid_rst_resp_valid", {63'd0, bi0.resp_valid}, 64'd0);
        chk("mid_rst_opA",        {32'd0, opa0}, 64'd0);
        chk("mid_rst_result",     {32'd0, bi0.resp_result}, 64'd0);
        chk("mid_rst_txn",        {48'd0, txn0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_req_ready", {63'd0, bi0.req_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_no_resp", {63'd0, bi0.resp_valid}, 64'd0);
        end

        // SETTLE_CYCLES=1: capture at the edge after accept
        bi1.req_a = 32'h0000_F0F0; bi1.req_b = 32'h0000_0FF0; bi1.req_cmd = ALU_XOR;
        bi1.req_valid = 1'b1;
        step();
        bi1.req_valid = 1'b0;
        n = 0;
        while (!bi1.resp_valid && n < 20) begin step(); n++; end
        chk("s1_latency", 64'(n), 64'd1);
        chk("s1_result",  {32'd0, bi1.resp_result}, 64'h0000_FF00);
        bi1.resp_ready = 1'b1;
        step();
        chk("s1_txn", {60'd0, txn1}, 64'd1);

        // Back-to-back: one transaction per 3 edges; 15 more wraps 4-bit count to 0
        bi1.req_a = 32'd2; bi1.req_b = 32'd3; bi1.req_cmd = ALU_AND;
        bi1.req_valid = 1'b1;
        for (int i = 0; i < 45; i++) step();
        chk("wrap_zero", {60'd0, txn1}, 64'd0);
        for (int i = 0; i < 3; i++) step();
        chk("wrap_one", {60'd0, txn1}, 64'd1);
        chk("wrap_idle", {63'd0, bi1.req_ready}, 64'd1);
        bi1.req_valid = 1'b0;
        bi1.resp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
